// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a frame FSM that
// shifts bytes out LSB-first, with a synchronized block input gating new frames.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 50,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  input  logic       block,
  output logic       tx,
  output logic       idle,
  output logic       overflow,
  output logic [1:0] dbg_state
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;
  localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0]      CYC_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]      CYC_ONE  = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   FULL     = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               block_m;
  logic               block_s;
  logic [7:0]         shift;
  logic [CW-1:0]      cyc;
  logic [2:0]         bit_idx;
  logic               push;
  logic               pop;

  // busy comes only from registered count so a producer can sample and strobe together.
  assign busy      = (count == FULL);
  assign push      = new_data && !busy;
  assign pop       = (state == S_IDLE) && (count != '0) && !block_s;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (new_data && busy) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_m <= 1'b0;
      block_s <= 1'b0;
    end else begin
      block_m <= block;
      block_s <= block_m;
    end
  end

  // tx is set together with each state change so it is a clean registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      idle    <= 1'b1;
      shift   <= '0;
      cyc     <= '0;
      bit_idx <= '0;
    end else begin
      idle <= (state == S_IDLE) && (count == '0);
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            cyc   <= '0;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cyc == CYC_LAST) begin
            cyc     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end
        S_DATA: begin
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (cyc == CYC_LAST) begin
            cyc   <= '0;
            state <= S_IDLE;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          cyc   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
